// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the two-port RAM arbiter / byte sequencer.
package ram_arbiter_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned RAM_RD_LAT = 1;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_CAPT,
    ST_WR,
    ST_DONE
  } state_t;

  // Little-endian byte lane k of a 32-bit word.
  function automatic logic [BYTE_W-1:0] byte_lane(input logic [WORD_W-1:0] w,
                                                  input logic [1:0] k);
    return w[{k, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker; on a tie the port not granted last wins.
import ram_arbiter_pkg::*;

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == PORT_DATA) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter that serialises 1-4 byte transfers onto a byte-wide RAM.
import ram_arbiter_pkg::*;

module ram_arbiter #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              ram_clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p0_we,
  input  logic [1:0]        p0_nbytes,
  input  logic [31:0]       p0_wdata,
  output logic              p0_done,
  output logic [31:0]       p0_rdata,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p1_we,
  input  logic [1:0]        p1_nbytes,
  input  logic [31:0]       p1_wdata,
  output logic              p1_done,
  output logic [31:0]       p1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  state_t              state;
  logic                last_grant;
  logic                sel;
  logic [ADDR_W-1:0]   addr;
  logic [1:0]          nbytes;
  logic [1:0]          k;
  logic [WORD_W-1:0]   wdata;
  logic [WORD_W-1:0]   asm_word;

  logic [1:0]          gnt;
  logic [ADDR_W-1:0]   g_addr;
  logic                g_we;
  logic [1:0]          g_nbytes;
  logic [WORD_W-1:0]   g_wdata;
  logic [1:0]          k_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [WORD_W-1:0]   asm_next;

  rr_arb2 u_rr (
    .req        ({p1_req, p0_req}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // Granted port's request fields, next byte address and word with the current lane filled in.
  always_comb begin
    g_addr    = gnt[1] ? p1_addr   : p0_addr;
    g_we      = gnt[1] ? p1_we     : p0_we;
    g_nbytes  = gnt[1] ? p1_nbytes : p0_nbytes;
    g_wdata   = gnt[1] ? p1_wdata  : p0_wdata;
    k_next    = k + 2'd1;
    addr_next = addr + ADDR_W'(k_next);
    asm_next  = asm_word;
    asm_next[{k, 3'b000} +: BYTE_W] = ram_dout;
  end

  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= PORT_DATA;
      sel        <= PORT_FETCH;
      addr       <= '0;
      nbytes     <= 2'd0;
      k          <= 2'd0;
      wdata      <= '0;
      asm_word   <= '0;
      p0_done    <= 1'b0;
      p1_done    <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= 8'd0;
    end else begin
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      ram_we  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            sel      <= gnt[1];
            addr     <= g_addr;
            nbytes   <= g_nbytes;
            wdata    <= g_wdata;
            k        <= 2'd0;
            asm_word <= '0;
            ram_addr <= g_addr;
            if (g_we) begin
              ram_we  <= 1'b1;
              ram_din <= byte_lane(g_wdata, 2'd0);
              state   <= ST_WR;
            end else begin
              state   <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: state <= ST_RD_CAPT;
        ST_RD_CAPT: begin
          asm_word <= asm_next;
          if (k == nbytes) begin
            state <= ST_DONE;
            if (sel == PORT_DATA) begin
              p1_done  <= 1'b1;
              p1_rdata <= asm_next;
            end else begin
              p0_done  <= 1'b1;
              p0_rdata <= asm_next;
            end
          end else begin
            k        <= k_next;
            ram_addr <= addr_next;
            state    <= ST_RD_ADDR;
          end
        end
        ST_WR: begin
          if (k == nbytes) begin
            state <= ST_DONE;
            if (sel == PORT_DATA) p1_done <= 1'b1;
            else                  p0_done <= 1'b1;
          end else begin
            k        <= k_next;
            ram_we   <= 1'b1;
            ram_addr <= addr_next;
            ram_din  <= byte_lane(wdata, k_next);
          end
        end
        ST_DONE: begin
          last_grant <= sel;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed transfers against a byte RAM model.
import ram_arbiter_pkg::*;

module tb_ram_arbiter;

  logic        ram_clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p1_addr;
  logic [1:0]  p0_nbytes, p1_nbytes;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_done, p1_done;
  logic [31:0] p0_rdata, p1_rdata;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = 8'd0;

  logic [7:0]  mem [0:65535];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct { logic is_read; logic [31:0] rdata; int at; } done_t;
  typedef struct { logic [15:0] a; logic [7:0] d; int at; } wr_t;
  done_t q0[$];
  done_t q1[$];
  wr_t   wq[$];

  ram_arbiter #(.ADDR_W(16)) dut (
    .ram_clk(ram_clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_we(p0_we), .p0_nbytes(p0_nbytes),
    .p0_wdata(p0_wdata), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_we(p1_we), .p1_nbytes(p1_nbytes),
    .p1_wdata(p1_wdata), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 ram_clk = ~ram_clk;
  always @(posedge ram_clk) cyc <= cyc + 1;

  // Byte RAM with one cycle of registered read latency.
  always @(posedge ram_clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_done(input int port, input logic [31:0] rdata);
    done_t e;
    if (port == 0 && q0.size() == 0 || port == 1 && q1.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_done port %0d at cycle %0d", port, cyc);
    end else begin
      e = (port == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("p%0d_done_cycle", port), 32'(cyc), 32'(e.at));
      if (e.is_read) chk($sformatf("p%0d_rdata", port), rdata, e.rdata);
    end
  endtask

  task automatic check_wr();
    wr_t e;
    if (wq.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_write addr 0x%04h data 0x%02h cycle %0d", ram_addr, ram_din, cyc);
    end else begin
      e = wq.pop_front();
      chk("wr_addr", 32'(ram_addr), 32'(e.a));
      chk("wr_data", 32'(ram_din), 32'(e.d));
      chk("wr_cycle", 32'(cyc), 32'(e.at));
    end
  endtask

  // Monitor: every done pulse and RAM write must match the head of its queue.
  always @(negedge ram_clk) begin
    if (!rst) begin
      if (p0_done) check_done(0, p0_rdata);
      if (p1_done) check_done(1, p1_rdata);
      if (ram_we)  check_wr();
    end
  end

  // Issue one transfer on a port (call at posedge+1) and hold req until done.
  task automatic issue(input int port, input logic [15:0] a, input logic we,
                       input logic [1:0] nb, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input int lat);
    done_t e;
    wr_t   w;
    logic  seen;
    int    start;
    start = cyc;
    e.is_read = !we; e.rdata = exp_rd; e.at = start + lat;
    if (port == 0) begin
      q0.push_back(e);
      p0_addr = a; p0_we = we; p0_nbytes = nb; p0_wdata = wd; p0_req = 1'b1;
    end else begin
      q1.push_back(e);
      p1_addr = a; p1_we = we; p1_nbytes = nb; p1_wdata = wd; p1_req = 1'b1;
    end
    if (we) begin
      for (int k = 0; k <= int'(nb); k++) begin
        w.a = a + 16'(k); w.d = 8'(wd >> (8 * k)); w.at = start + 1 + k;
        wq.push_back(w);
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge ram_clk);
      seen = (port == 0) ? p0_done : p1_done;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL timeout port %0d: no done within 40 cycles", port);
    end
    @(posedge ram_clk); #1;
    if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
  endtask

  initial begin
    int   start;
    wr_t  w;
    logic [31:0] word;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h11 * (i + 1));
    mem[16'hFFFE] = 8'hAA;
    mem[16'hFFFF] = 8'hBB;
    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_nbytes = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_nbytes = 0; p1_wdata = 0;
    repeat (2) @(posedge ram_clk);
    #1;
    chk("rst_p0_done", 32'(p0_done), 0);
    chk("rst_p1_done", 32'(p1_done), 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_p1_rdata", p1_rdata, 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_din", 32'(ram_din), 0);
    rst = 1'b0;

    // 4-byte fetch from 0; no RAM writes may appear
    @(posedge ram_clk); #1;
    issue(0, 16'h0000, 1'b0, 2'd3, 32'h0, 32'h44332211, 9);
    // 2-byte data write then read back
    @(posedge ram_clk); #1;
    issue(1, 16'h0100, 1'b1, 2'd1, 32'h0000BEEF, 32'h0, 3);
    @(posedge ram_clk); #1;
    issue(1, 16'h0100, 1'b0, 2'd1, 32'h0, 32'h0000BEEF, 5);
    // Tie with last_grant = 1: port 0 first (1-byte read at 5), then port 1
    @(posedge ram_clk); #1;
    fork
      issue(0, 16'h0005, 1'b0, 2'd0, 32'h0, 32'h00000066, 3);
      issue(1, 16'h0000, 1'b0, 2'd0, 32'h0, 32'h00000011, 7);
    join
    // Address wrap across 0xFFFF
    @(posedge ram_clk); #1;
    issue(0, 16'hFFFE, 1'b0, 2'd3, 32'h0, 32'h2211BBAA, 9);
    // Tie with last_grant = 0: port 1 first
    @(posedge ram_clk); #1;
    fork
      issue(0, 16'h0000, 1'b0, 2'd0, 32'h0, 32'h00000011, 7);
      issue(1, 16'h0001, 1'b0, 2'd0, 32'h0, 32'h00000022, 3);
    join

    // Reset in cycle 4 of a 4-byte write: only bytes 0-2 land
    @(posedge ram_clk); #1;
    start = cyc;
    p1_addr = 16'h0200; p1_we = 1'b1; p1_nbytes = 2'd3; p1_wdata = 32'hDDCCBBAA; p1_req = 1'b1;
    word = 32'hDDCCBBAA;
    for (int k = 0; k < 3; k++) begin
      w.a = 16'h0200 + 16'(k); w.d = word[8*k +: 8]; w.at = start + 1 + k;
      wq.push_back(w);
    end
    repeat (4) @(posedge ram_clk);
    #2;
    chk("mid_cycle4", 32'(cyc), 32'(start + 4));
    rst = 1'b1;
    #1;
    chk("rst_async_ram_we", 32'(ram_we), 0);
    chk("rst_async_p1_done", 32'(p1_done), 0);
    chk("rst_async_p1_rdata", p1_rdata, 0);
    p1_req = 1'b0;
    repeat (2) @(posedge ram_clk);
    #1;
    rst = 1'b0;
    chk("partial_b0", 32'(mem[16'h0200]), 32'hAA);
    chk("partial_b1", 32'(mem[16'h0201]), 32'hBB);
    chk("partial_b2", 32'(mem[16'h0202]), 32'hCC);
    chk("partial_b3", 32'(mem[16'h0203]), 32'h00);
    chk("wq_drained", 32'(wq.size()), 0);
    // Normal grant after reset release
    @(posedge ram_clk); #1;
    issue(0, 16'h0200, 1'b0, 2'd0, 32'h0, 32'h000000AA, 3);

    repeat (3) @(posedge ram_clk);
    #1;
    chk("q0_empty", 32'(q0.size()), 0);
    chk("q1_empty", 32'(q1.size()), 0);
    chk("wq_empty", 32'(wq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
